// File: rtl/core_pkg.sv
// Shared core definitions: load funct3 encodings and writeback hold-buffer state.
package core_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } wb_hold_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a load response and sign/zero-extends it.
module load_align
    import core_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        // Halfword loads ignore addr_lo[0]; misaligned halves are the core's problem.
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      result = {{(WORD_SIZE-8){byte_sel[7]}}, byte_sel};
            LH:      result = {{(WORD_SIZE-16){half_sel[15]}}, half_sel};
            LBU:     result = {{(WORD_SIZE-8){1'b0}}, byte_sel};
            LHU:     result = {{(WORD_SIZE-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: merges execute results and load responses into one registered
// register-file write port, with a one-entry hold buffer and a pending-load scoreboard.
module writeback_stage
    import core_pkg::*;
#(
    parameter int WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    output logic                 ex_ready,
    input  logic [4:0]           ex_rd,
    input  logic [WORD_SIZE-1:0] ex_data,
    input  logic                 ld_issue,
    input  logic [4:0]           ld_issue_rd,
    input  logic                 mem_valid,
    input  logic [4:0]           mem_rd,
    input  logic [2:0]           mem_funct3,
    input  logic [1:0]           mem_addr_lo,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [WORD_SIZE-1:0] wb_data,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    output logic                 hazard
);

    wb_hold_e             state;
    logic [4:0]           hold_rd;
    logic [WORD_SIZE-1:0] hold_data;
    logic [WORD_SIZE-1:0] ld_data;
    logic [31:0]          busy;
    logic [31:0]          busy_nxt;
    logic                 ex_acc;
    logic                 rs1_pend;
    logic                 rs2_pend;

    load_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .funct3  (mem_funct3),
        .addr_lo (mem_addr_lo),
        .rdata   (mem_rdata),
        .result  (ld_data)
    );

    assign ex_ready = (state == EMPTY);
    assign ex_acc   = ex_valid && ex_ready;

    // Load responses cannot stall, so they always win; a colliding execute result parks in hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            hold_rd   <= '0;
            hold_data <= '0;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            if (mem_valid) begin
                wb_en   <= (mem_rd != 5'd0);
                wb_rd   <= mem_rd;
                wb_data <= ld_data;
                if (ex_acc) begin
                    state     <= HELD;
                    hold_rd   <= ex_rd;
                    hold_data <= ex_data;
                end
            end else if (state == HELD) begin
                wb_en   <= (hold_rd != 5'd0);
                wb_rd   <= hold_rd;
                wb_data <= hold_data;
                state   <= EMPTY;
            end else if (ex_acc) begin
                wb_en   <= (ex_rd != 5'd0);
                wb_rd   <= ex_rd;
                wb_data <= ex_data;
            end else begin
                wb_en   <= 1'b0;
            end
        end
    end

    // Set is applied after clear so a same-index issue/response pair leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (mem_valid)
            busy_nxt[mem_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0)
            busy_nxt[ld_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign rs1_pend = (rs1 != 5'd0) && (busy[rs1] || (wb_en && wb_rd == rs1));
    assign rs2_pend = (rs2 != 5'd0) && (busy[rs2] || (wb_en && wb_rd == rs2));
    assign hazard   = rs1_pend || rs2_pend;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed + randomized bench for writeback_stage against a queue-based reference model.
module tb_writeback_stage;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;

    int checks = 0;
    int errors = 0;

    // Reference model state
    item_t       hold_q[$];
    bit          pend[32];
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    writeback_stage #(.WORD_SIZE(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ld_issue    (ld_issue),
        .ld_issue_rd (ld_issue_rd),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_funct3  (mem_funct3),
        .mem_addr_lo (mem_addr_lo),
        .mem_rdata   (mem_rdata),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0: begin
                v = (w >> (8 * off)) & 32'hFF;
                if (v >= 32'd128) v = v | 32'hFFFF_FF00;
            end
            3'd1: begin
                v = (w >> (16 * (off / 2))) & 32'hFFFF;
                if (v >= 32'd32768) v = v | 32'hFFFF_0000;
            end
            3'd4:    v = (w >> (8 * off)) & 32'hFF;
            3'd5:    v = (w >> (16 * (off / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic ref_src_hazard(input logic [4:0] rs);
        if (rs == 0) return 1'b0;
        return pend[rs] || (m_en && m_rd == rs);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hold_q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        m_en   = 1'b0;
        m_rd   = '0;
        m_data = '0;
    endtask

    task automatic idle_inputs();
        ex_valid  = 1'b0;
        ld_issue  = 1'b0;
        mem_valid = 1'b0;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check wb_* after it.
    task automatic tick();
        bit    acc;
        bit    sel;
        item_t it;
        @(negedge clk);
        chk("ex_ready", ex_ready, hold_q.size() == 0);
        chk("hazard", hazard, ref_src_hazard(rs1) || ref_src_hazard(rs2));
        acc = ex_valid && hold_q.size() == 0;
        sel = 1'b0;
        if (mem_valid) begin
            sel     = 1'b1;
            it.rd   = mem_rd;
            it.data = ref_load(mem_funct3, mem_addr_lo, mem_rdata);
            if (acc) hold_q.push_back('{ex_rd, ex_data});
        end else if (hold_q.size() != 0) begin
            sel = 1'b1;
            it  = hold_q.pop_front();
        end else if (acc) begin
            sel     = 1'b1;
            it.rd   = ex_rd;
            it.data = ex_data;
        end
        if (mem_valid) pend[mem_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 0) pend[ld_issue_rd] = 1'b1;
        m_en = sel && it.rd != 0;
        if (sel) begin
            m_rd   = it.rd;
            m_data = it.data;
        end
        @(posedge clk);
        #1;
        chk("wb_en", wb_en, m_en);
        if (m_en) begin
            chk("wb_rd", wb_rd, m_rd);
            chk("wb_data", wb_data, m_data);
        end
    endtask

    task automatic mem_resp(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                            input logic [31:0] w);
        mem_valid   = 1'b1;
        mem_rd      = rd;
        mem_funct3  = f3;
        mem_addr_lo = off;
        mem_rdata   = w;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        ex_rd = '0; ex_data = '0; ld_issue_rd = '0; mem_rd = '0;
        mem_funct3 = '0; mem_addr_lo = '0; mem_rdata = '0;
        rs1 = 5'd9; rs2 = 5'd0;
        model_reset();

        // Reset state
        #12;
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_hazard", hazard, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // LB, sign-extended top byte
        mem_resp(5'd5, 3'b000, 2'd3, 32'h80FF_0000);
        tick(); idle_inputs();
        chk("lb_en", wb_en, 1'b1);
        chk("lb_rd", wb_rd, 5'd5);
        chk("lb_data", wb_data, 32'hFFFF_FF80);

        // LHU / LH on the upper halfword
        mem_resp(5'd7, 3'b101, 2'd2, 32'hBEEF_1234);
        tick(); idle_inputs();
        chk("lhu_data", wb_data, 32'h0000_BEEF);
        mem_resp(5'd7, 3'b001, 2'd2, 32'hBEEF_1234);
        tick(); idle_inputs();
        chk("lh_data", wb_data, 32'hFFFF_BEEF);

        // Collision: load first, execute result from hold next
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h11;
        mem_resp(5'd4, 3'b010, 2'd1, 32'hCAFE_F00D);
        tick(); idle_inputs();
        chk("col1_rd", wb_rd, 5'd4);
        chk("col1_data", wb_data, 32'hCAFE_F00D);
        chk("col1_ready", ex_ready, 1'b0);
        tick();
        chk("col2_en", wb_en, 1'b1);
        chk("col2_rd", wb_rd, 5'd3);
        chk("col2_data", wb_data, 32'h11);
        chk("col2_ready", ex_ready, 1'b1);

        // Scoreboard on x9
        rs1 = 5'd9;
        ld_issue = 1'b1; ld_issue_rd = 5'd9;
        tick(); idle_inputs();
        chk("sb_set", hazard, 1'b1);
        tick();
        chk("sb_hold", hazard, 1'b1);
        mem_resp(5'd9, 3'b010, 2'd0, 32'h1234_5678);
        tick(); idle_inputs();
        chk("sb_wb_en", wb_en, 1'b1);
        chk("sb_wb_cycle", hazard, 1'b1);
        tick();
        chk("sb_clear", hazard, 1'b0);
        ld_issue = 1'b1; ld_issue_rd = 5'd0;
        tick(); idle_inputs();
        chk("sb_x0", hazard, 1'b0);

        // Execute write to x0 consumes the slot without a write
        ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hDEAD;
        tick(); idle_inputs();
        chk("x0_en", wb_en, 1'b0);
        chk("x0_ready", ex_ready, 1'b1);

        // Reset while HELD, with a load outstanding
        ex_valid = 1'b1; ex_rd = 5'd6; ex_data = 32'h55;
        ld_issue = 1'b1; ld_issue_rd = 5'd12;
        mem_resp(5'd8, 3'b010, 2'd0, 32'h8888);
        tick(); idle_inputs();
        chk("held_ready", ex_ready, 1'b0);
        rs1 = 5'd12; rs2 = 5'd6;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_en", wb_en, 1'b0);
        chk("mid_rst_rd", wb_rd, 5'd0);
        chk("mid_rst_data", wb_data, 32'd0);
        chk("mid_rst_ready", ex_ready, 1'b1);
        chk("mid_rst_hazard", hazard, 1'b0);
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("post_rst_en", wb_en, 1'b0);
        tick();
        chk("post_rst_en2", wb_en, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            ex_valid    = ($urandom_range(0, 99) < 50);
            ex_rd       = 5'($urandom_range(0, 31));
            ex_data     = $urandom;
            ld_issue    = ($urandom_range(0, 99) < 30);
            ld_issue_rd = 5'($urandom_range(0, 31));
            mem_valid   = ($urandom_range(0, 99) < 40);
            mem_rd      = 5'($urandom_range(0, 31));
            mem_funct3  = 3'($urandom_range(0, 7));
            mem_addr_lo = 2'($urandom_range(0, 3));
            mem_rdata   = $urandom;
            rs1         = 5'($urandom_range(0, 31));
            rs2         = 5'($urandom_range(0, 31));
            tick();
        end
        idle_inputs();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
